// File: rtl/led_pattern_ctrl_pkg.sv
// Shared encodings for the LED pattern controller: mode codes, per-mode seed
// values and ping-pong direction.
package led_pattern_ctrl_pkg;

    localparam logic [1:0] MODE_FILL     = 2'd0;
    localparam logic [1:0] MODE_CHASE    = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_BLINK    = 2'd3;

    localparam logic [7:0] SEED_FILL     = 8'h00;
    localparam logic [7:0] SEED_CHASE    = 8'h01;
    localparam logic [7:0] SEED_PINGPONG = 8'h01;
    localparam logic [7:0] SEED_BLINK    = 8'h00;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic logic [7:0] mode_seed(input logic [1:0] m);
        case (m)
            MODE_FILL:     return SEED_FILL;
            MODE_CHASE:    return SEED_CHASE;
            MODE_PINGPONG: return SEED_PINGPONG;
            default:       return SEED_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_key_debounce.sv
// Push-button debouncer: 2-FF synchroniser, stability counter, one-cycle pulse
// on an accepted press (debounced 1->0).
module key_debounce
    import led_pattern_ctrl_pkg::*;
#(
    parameter logic [19:0] DEB_CNT = 20'd999_999
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic        sync1;
    logic        sync2;
    logic        db;
    logic [1:0]  fill;
    logic        armed;
    logic [19:0] cnt;

    // A key already held through reset must be seen released before it can
    // generate a press; fill marks when sync2 reflects the real pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            db    <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & sync2);
            press <= 1'b0;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == DEB_CNT) begin
                cnt   <= '0;
                db    <= sync2;
                press <= db & armed;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// 8-LED pattern sequencer: four patterns stepped by a speed-scaled tick,
// mode and speed selected by two debounced push-buttons.
module led_pattern_ctrl
    import led_pattern_ctrl_pkg::*;
#(
    parameter logic [25:0] TICK_BASE = 26'd49_999_999,
    parameter logic [19:0] DEB_CNT   = 20'd999_999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_speed_n,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed
);

    logic        mode_press;
    logic        speed_press;
    logic [25:0] period;
    logic [25:0] term;
    logic [25:0] cnt;
    logic        tick;
    logic        dir;
    logic [1:0]  mode_next;
    logic [7:0]  step_led;
    logic        step_dir;

    key_debounce #(.DEB_CNT(DEB_CNT)) u_mode_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_mode_n),
        .press (mode_press)
    );

    key_debounce #(.DEB_CNT(DEB_CNT)) u_speed_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_speed_n),
        .press (speed_press)
    );

    assign period    = (TICK_BASE + 26'd1) >> speed;
    assign term      = period - 26'd1;
    assign mode_next = mode + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == term);
            if (mode_press || speed_press || (cnt == term))
                cnt <= '0;
            else
                cnt <= cnt + 26'd1;
        end
    end

    always_comb begin
        step_led = led;
        step_dir = dir;
        case (mode)
            MODE_FILL:  step_led = (led == 8'hFF) ? 8'h00 : {led[6:0], 1'b1};
            MODE_CHASE: step_led = {led[6:0], led[7]};
            MODE_PINGPONG: begin
                // Direction flips on the step that reaches an end, so the end
                // value is shown once and never repeated.
                if (dir == DIR_LEFT) begin
                    step_led = {led[6:0], 1'b0};
                    if (led == 8'h40) step_dir = DIR_RIGHT;
                end else begin
                    step_led = {1'b0, led[7:1]};
                    if (led == 8'h02) step_dir = DIR_LEFT;
                end
            end
            default:    step_led = ~led;
        endcase
    end

    // A mode press reloads the seed and overrides any tick in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led   <= 8'h00;
            mode  <= MODE_FILL;
            speed <= 2'd0;
            dir   <= DIR_LEFT;
        end else begin
            if (mode_press) begin
                mode <= mode_next;
                led  <= mode_seed(mode_next);
                dir  <= DIR_LEFT;
            end else if (tick) begin
                led <= step_led;
                dir <= step_dir;
            end
            if (speed_press)
                speed <= speed + 2'd1;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with TICK_BASE=15, DEB_CNT=3.
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode_n;
    logic       key_speed_n;
    logic [7:0] led;
    logic [1:0] mode;
    logic [1:0] speed;

    int compared   = 0;
    int mismatched = 0;
    int c;
    int ch1;
    int ch2;

    led_pattern_ctrl #(.TICK_BASE(26'd15), .DEB_CNT(20'd3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_mode_n  (key_mode_n),
        .key_speed_n (key_speed_n),
        .led         (led),
        .mode        (mode),
        .speed       (speed)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps until led changes (max 64 cycles); returns the cycles taken.
    task automatic wait_change(output int cyc);
        logic [7:0] prev;
        prev = led;
        cyc  = 0;
        do begin
            step(1);
            cyc++;
        end while (led === prev && cyc < 64);
    endtask

    task automatic step_count(input int n, output int changes);
        logic [7:0] prev;
        changes = 0;
        repeat (n) begin
            prev = led;
            step(1);
            if (led !== prev) changes++;
        end
    endtask

    logic [7:0] fill_seq [8]  = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    logic [7:0] chase_seq [7] = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] pp_seq [14]   = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    initial begin
        rst_n       = 1'b0;
        key_mode_n  = 1'b1;
        key_speed_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_led", led, 8'h00);
        chk("reset_mode", mode, 2'd0);
        chk("reset_speed", speed, 2'd0);
        rst_n = 1'b1;

        // 1: FILL from reset, first step 17 edges after release then every 16
        step(16);
        chk("fill_hold", led, 8'h00);
        step(1);
        chk("fill_first", led, 8'h01);
        for (int i = 0; i < 8; i++) begin
            step(16);
            chk($sformatf("fill_%0d", i), led, fill_seq[i]);
        end
        chk("fill_mode", mode, 2'd0);
        chk("fill_speed", speed, 2'd0);

        // 2: glitch rejected, then clean press into CHASE
        key_mode_n = 1'b0;
        step(2);
        key_mode_n = 1'b1;
        step(4);
        chk("glitch_mode", mode, 2'd0);
        chk("glitch_led", led, 8'h00);
        key_mode_n = 1'b0;
        step(6);
        chk("press_latency_mode", mode, 2'd0);
        step(1);
        chk("chase_mode", mode, 2'd1);
        chk("chase_seed", led, 8'h01);
        step(3);
        key_mode_n = 1'b1;
        step(13);
        chk("chase_hold", led, 8'h01);
        step(1);
        chk("chase_first", led, 8'h02);
        for (int i = 0; i < 7; i++) begin
            step(16);
            chk($sformatf("chase_%0d", i), led, chase_seq[i]);
        end
        chk("release_no_press", mode, 2'd1);

        // 3: PINGPONG
        key_mode_n = 1'b0;
        step(6);
        chk("pp_pre_mode", mode, 2'd1);
        step(1);
        chk("pp_mode", mode, 2'd2);
        chk("pp_seed", led, 8'h01);
        step(3);
        key_mode_n = 1'b1;
        step(13);
        chk("pp_hold", led, 8'h01);
        step(1);
        chk("pp_first", led, 8'h02);
        for (int i = 0; i < 14; i++) begin
            step(16);
            chk($sformatf("pp_%0d", i), led, pp_seq[i]);
        end

        // 4: speed presses, period 16 -> 8 -> 4 -> 2 -> 16
        key_speed_n = 1'b0;
        step_count(6, ch1);
        chk("spd1_pre", speed, 2'd0);
        step_count(1, ch2);
        chk("spd1", speed, 2'd1);
        chk("spd1_steps_in_press", ch1 + ch2, 0);
        key_speed_n = 1'b1;
        wait_change(c);
        chk("spd1_first", c, 9);
        wait_change(c);
        chk("spd1_period", c, 8);

        step(2);
        key_speed_n = 1'b0;
        step_count(6, ch1);
        step_count(1, ch2);
        chk("spd2", speed, 2'd2);
        chk("spd2_steps_in_press", ch1 + ch2, 1);
        key_speed_n = 1'b1;
        wait_change(c);
        chk("spd2_first", c, 5);
        wait_change(c);
        chk("spd2_period", c, 4);

        step(2);
        key_speed_n = 1'b0;
        step_count(6, ch1);
        step_count(1, ch2);
        chk("spd3", speed, 2'd3);
        chk("spd3_steps_in_press", ch1 + ch2, 2);
        key_speed_n = 1'b1;
        wait_change(c);
        chk("spd3_first", c, 3);
        wait_change(c);
        chk("spd3_period", c, 2);

        step(1);
        key_speed_n = 1'b0;
        step_count(6, ch1);
        step_count(1, ch2);
        chk("spd_wrap", speed, 2'd0);
        chk("spd_coincident_step", ch2, 1);
        chk("spd4_steps_in_press", ch1 + ch2, 4);
        key_speed_n = 1'b1;
        wait_change(c);
        chk("spd4_first", c, 17);
        wait_change(c);
        chk("spd4_period", c, 16);

        // 5: BLINK, then both keys in the same cycle
        key_mode_n = 1'b0;
        step(6);
        step(1);
        chk("blink_mode", mode, 2'd3);
        chk("blink_seed", led, 8'h00);
        key_mode_n = 1'b1;
        wait_change(c);
        chk("blink_first", c, 17);
        chk("blink_ff", led, 8'hFF);
        key_mode_n  = 1'b0;
        key_speed_n = 1'b0;
        step(6);
        chk("both_pre_led", led, 8'hFF);
        step(1);
        chk("both_mode", mode, 2'd0);
        chk("both_speed", speed, 2'd1);
        chk("both_led", led, 8'h00);
        key_mode_n  = 1'b1;
        key_speed_n = 1'b1;
        wait_change(c);
        chk("both_first", c, 9);
        chk("both_first_led", led, 8'h01);
        wait_change(c);
        chk("both_period", c, 8);
        chk("both_second_led", led, 8'h03);

        // 6: async reset mid-CHASE with the mode key held
        step(2);
        key_mode_n = 1'b0;
        step(7);
        chk("r_chase_mode", mode, 2'd1);
        chk("r_chase_seed", led, 8'h01);
        key_mode_n = 1'b1;
        wait_change(c);
        chk("r_chase_first", c, 9);
        chk("r_chase_led", led, 8'h02);
        key_mode_n = 1'b0;
        step(4);
        chk("r_pre_speed", speed, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_led", led, 8'h00);
        chk("r_async_mode", mode, 2'd0);
        chk("r_async_speed", speed, 2'd0);
        step(2);
        chk("r_held_led", led, 8'h00);
        rst_n = 1'b1;
        step(16);
        chk("r_fill_hold", led, 8'h00);
        step(1);
        chk("r_fill_first", led, 8'h01);
        step(10);
        chk("r_held_no_press", mode, 2'd0);
        key_mode_n = 1'b1;
        step(10);
        chk("r_release_no_press", mode, 2'd0);
        key_mode_n = 1'b0;
        step(7);
        chk("r_repress_mode", mode, 2'd1);
        chk("r_repress_led", led, 8'h01);
        key_mode_n = 1'b1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
